// File: rtl/cmp_frame_sequencer.sv
// Anti-probe measurement frame sequencer in the shifting_clk domain.
// Emits sync preamble, settles swing drivers, packs comparator samples, closes with a trailer.
module cmp_frame_sequencer #(
    parameter logic [31:0] IDLE_WORD   = 32'h5A5A_5A5A,
    parameter logic [31:0] SYNC_WORD   = 32'hA5C3_3C5A,
    parameter int          SYNC_COUNT  = 4,
    parameter int          LEAD_CYCLES = 8,
    parameter int          FRAME_WORDS = 16
) (
    input  logic        shifting_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        link_up,
    input  logic        cmp_ref,
    input  logic        cmp_s11,
    input  logic        cmp_s21,
    output logic [31:0] gth_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        swing_en,
    output logic        triger,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        overflow
);

    localparam logic [7:0]  SYNC_N    = 8'(SYNC_COUNT);
    localparam logic [7:0]  SYNC_LAST = 8'(SYNC_COUNT - 1);
    localparam logic [7:0]  LEAD_LAST = 8'(LEAD_CYCLES - 1);
    localparam logic [15:0] WORD_LAST = 16'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_SETTLE, S_CAPTURE, S_TRAILER, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        K_IDLE, K_SYNC, K_DATA, K_TRL
    } kind_t;

    state_t      state;
    state_t      state_nxt;
    kind_t       kind;
    kind_t       load_kind;
    logic [31:0] load_word;
    logic        load_en;
    logic        drop;
    logic        free;
    logic        accept;
    logic        sync_ack;
    logic        last_sample;
    logic        last_word;
    logic [7:0]  sync_loaded;
    logic [7:0]  sync_acked;
    logic [7:0]  lead_cnt;
    logic [3:0]  samp_idx;
    logic [15:0] word_idx;
    logic [29:0] pack;
    logic        pend;
    logic        pend_last;
    logic        trl_loaded;

    assign free        = !word_valid || word_ready;
    assign accept      = word_valid && word_ready;
    assign sync_ack    = accept && (kind == K_SYNC);
    assign last_sample = (samp_idx == 4'd9);
    assign last_word   = (word_idx == WORD_LAST);

    always_ff @(posedge shifting_clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        swing_en  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && link_up) state_nxt = S_SYNC;
            end
            S_SYNC: begin
                swing_en = 1'b1;
                if (sync_ack && sync_acked == SYNC_LAST) state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                swing_en = 1'b1;
                if (lead_cnt == LEAD_LAST) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                swing_en = 1'b1;
                if (last_sample && last_word) state_nxt = S_TRAILER;
            end
            S_TRAILER: begin
                if (accept && kind == K_TRL) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Link loss abandons the frame from any active state.
        if (state != S_IDLE && !link_up) begin
            state_nxt = S_IDLE;
            swing_en  = 1'b0;
        end
    end

    always_comb begin
        load_en   = 1'b0;
        load_word = IDLE_WORD;
        load_kind = K_IDLE;
        drop      = 1'b0;
        if (state == S_IDLE) begin
            load_en = free;
        end else if (link_up) begin
            unique case (state)
                S_SYNC: begin
                    if (free && sync_loaded != SYNC_N) begin
                        load_en   = 1'b1;
                        load_word = SYNC_WORD;
                        load_kind = K_SYNC;
                    end
                end
                S_CAPTURE, S_TRAILER: begin
                    if (pend) begin
                        load_en   = free;
                        drop      = !free;
                        load_word = {(pend_last ? 2'b11 : 2'b01), pack};
                        load_kind = K_DATA;
                    end else if (state == S_TRAILER && !trl_loaded && free) begin
                        load_en   = 1'b1;
                        load_word = {2'b10, overflow, 13'b0, frame_cnt};
                        load_kind = K_TRL;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge shifting_clk or posedge reset) begin
        if (reset) begin
            gth_data    <= IDLE_WORD;
            word_valid  <= 1'b0;
            kind        <= K_IDLE;
            pend        <= 1'b0;
            pend_last   <= 1'b0;
            pack        <= '0;
            sync_loaded <= '0;
            sync_acked  <= '0;
            lead_cnt    <= '0;
            samp_idx    <= '0;
            word_idx    <= '0;
            trl_loaded  <= 1'b0;
            triger      <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            overflow    <= 1'b0;
        end else begin
            if (load_en) begin
                gth_data   <= load_word;
                word_valid <= 1'b1;
                kind       <= load_kind;
            end else if (accept) begin
                word_valid <= 1'b0;
            end
            pend      <= (state == S_CAPTURE) && last_sample && link_up;
            pend_last <= last_word;
            // Shift in from the top so sample 0 lands in bits [2:0].
            if (state == S_CAPTURE) pack <= {cmp_s21, cmp_s11, cmp_ref, pack[29:3]};
            sync_loaded <= (state == S_SYNC) ? sync_loaded + 8'(load_en) : 8'd0;
            sync_acked  <= (state == S_SYNC) ? sync_acked + 8'(sync_ack) : 8'd0;
            lead_cnt    <= (state == S_SETTLE) ? lead_cnt + 8'd1 : 8'd0;
            if (state != S_CAPTURE) begin
                samp_idx <= '0;
                word_idx <= '0;
            end else if (last_sample) begin
                samp_idx <= '0;
                word_idx <= word_idx + 16'd1;
            end else begin
                samp_idx <= samp_idx + 4'd1;
            end
            trl_loaded <= (state == S_TRAILER) &&
                          (trl_loaded || (load_en && load_kind == K_TRL));
            triger     <= (state == S_SETTLE) && (state_nxt == S_CAPTURE);
            frame_done <= (state == S_TRAILER) && (state_nxt == S_DONE);
            if (state == S_DONE && link_up) frame_cnt <= frame_cnt + 16'd1;
            if (state == S_IDLE && state_nxt == S_SYNC) overflow <= 1'b0;
            else if (drop)                              overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cmp_frame_sequencer.sv
// Directed testbench for cmp_frame_sequencer: default-parameter frames plus a
// minimal-frame instance (1 sync, 1 lead cycle, 1 word) for counter wrap.
module tb_cmp_frame_sequencer;

    localparam logic [31:0] IDLE_W = 32'h5A5A_5A5A;
    localparam logic [31:0] SYNC_W = 32'hA5C3_3C5A;

    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        reset, start, start2, link_up, word_ready;
    logic        cmp_ref, cmp_s11, cmp_s21;
    logic [31:0] gth_data, gth_data2;
    logic        word_valid, swing_en, triger, busy, frame_done, overflow;
    logic        word_valid2, swing_en2, triger2, busy2, frame_done2, overflow2;
    logic [15:0] frame_cnt, frame_cnt2;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    int pat_mode = 0;
    int samp_k   = 0;
    wq_t q, q2;

    cmp_frame_sequencer dut (
        .shifting_clk(clk), .reset(reset), .start(start), .link_up(link_up),
        .cmp_ref(cmp_ref), .cmp_s11(cmp_s11), .cmp_s21(cmp_s21),
        .gth_data(gth_data), .word_valid(word_valid), .word_ready(word_ready),
        .swing_en(swing_en), .triger(triger), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .overflow(overflow)
    );

    cmp_frame_sequencer #(.SYNC_COUNT(1), .LEAD_CYCLES(1), .FRAME_WORDS(1)) dut_min (
        .shifting_clk(clk), .reset(reset), .start(start2), .link_up(link_up),
        .cmp_ref(cmp_ref), .cmp_s11(cmp_s11), .cmp_s21(cmp_s21),
        .gth_data(gth_data2), .word_valid(word_valid2), .word_ready(word_ready),
        .swing_en(swing_en2), .triger(triger2), .busy(busy2),
        .frame_done(frame_done2), .frame_cnt(frame_cnt2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    // Record every accepted non-idle word; sampled mid-cycle, before the accepting edge.
    always @(negedge clk) begin
        if (word_valid && word_ready && gth_data != IDLE_W) q.push_back(gth_data);
        if (word_valid2 && word_ready && gth_data2 != IDLE_W) q2.push_back(gth_data2);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sample index restarts on the triger cycle so sample 0 meets the first capture edge.
    // Pattern 1: even samples {s21,s11,ref}=3'b101, odd samples 3'b100.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (triger) samp_k = 0;
            else        samp_k++;
            cmp_ref = (pat_mode != 0) && ((samp_k % 10) % 2 == 0);
            cmp_s11 = 1'b0;
            cmp_s21 = (pat_mode != 0);
        end
    end

    function automatic wq_t mk_exp(input int ns, input int nd, input logic [31:0] dw,
                                   input logic [31:0] lw, input logic [31:0] tw);
        wq_t e;
        for (int i = 0; i < ns; i++) e.push_back(SYNC_W);
        for (int i = 0; i < nd - 1; i++) e.push_back(dw);
        e.push_back(lw);
        e.push_back(tw);
        return e;
    endfunction

    task automatic wait_idle(input bit sel, output int trig_at, output int trig_n,
                             output int done_n);
        trig_at = -1;
        trig_n  = 0;
        done_n  = 0;
        for (int i = 1; i <= 600; i++) begin
            tick();
            if (sel ? triger2 : triger) begin
                trig_n++;
                if (trig_at < 0) trig_at = i;
            end
            if (sel ? frame_done2 : frame_done) done_n++;
            if (!(sel ? busy2 : busy)) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; start2 = 0; link_up = 1; word_ready = 1;
        cmp_ref = 0; cmp_s11 = 0; cmp_s21 = 0;
        tick(2);
        n_checks++;
        if ({gth_data, word_valid, swing_en, triger, busy, frame_done, frame_cnt, overflow}
            !== {IDLE_W, 5'b0, 16'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got data=%h v=%b sw=%b tr=%b bz=%b fd=%b cnt=%h ov=%b",
                     gth_data, word_valid, swing_en, triger, busy, frame_done, frame_cnt, overflow);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({word_valid, gth_data} !== {1'b1, IDLE_W}) begin
            n_fail++;
            $display("FAIL idle_after_reset: got v=%b data=%h want v=1 data=%h",
                     word_valid, gth_data, IDLE_W);
        end
    endtask

    task automatic test_basic();
        int ta, tn, dn;
        wq_t e;
        logic [31:0] got;
        pat_mode = 0;
        q.delete();
        start = 1; tick(); start = 0;
        n_checks++;
        if ({busy, swing_en} !== 2'b11) begin
            n_fail++;
            $display("FAIL basic_start: got busy=%b swing=%b want 1 1", busy, swing_en);
        end
        wait_idle(0, ta, tn, dn);
        n_checks++;
        if (ta !== 13 || tn !== 1) begin
            n_fail++;
            $display("FAIL basic_triger: got at=%0d n=%0d want at=13 n=1", ta, tn);
        end
        n_checks++;
        if (dn !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got pulses=%0d busy=%b want 1 0", dn, busy);
        end
        exp_cnt++;
        n_checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL basic_cnt: got %0d want %0d", frame_cnt, exp_cnt);
        end
        e = mk_exp(4, 16, 32'h4000_0000, 32'hC000_0000, 32'h8000_0000);
        n_checks++;
        if (q.size() !== e.size()) begin
            n_fail++;
            $display("FAIL basic_len: got %0d words want %0d", q.size(), e.size());
        end
        for (int i = 0; i < e.size(); i++) begin
            got = (i < q.size()) ? q[i] : 'x;
            n_checks++;
            if (got !== e[i]) begin
                n_fail++;
                $display("FAIL basic_word[%0d]: got %h want %h", i, got, e[i]);
            end
        end
    endtask

    task automatic test_packing();
        int ta, tn, dn;
        wq_t e;
        logic [31:0] got;
        pat_mode = 1;
        q.delete();
        start = 1; tick(); start = 0;
        wait_idle(0, ta, tn, dn);
        pat_mode = 0;
        exp_cnt++;
        n_checks++;
        if (dn !== 1 || frame_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL pack_done: got pulses=%0d cnt=%0d want 1 %0d", dn, frame_cnt, exp_cnt);
        end
        e = mk_exp(4, 16, 32'h6596_5965, 32'hE596_5965, 32'h8000_0001);
        n_checks++;
        if (q.size() !== e.size()) begin
            n_fail++;
            $display("FAIL pack_len: got %0d words want %0d", q.size(), e.size());
        end
        for (int i = 0; i < e.size(); i++) begin
            got = (i < q.size()) ? q[i] : 'x;
            n_checks++;
            if (got !== e[i]) begin
                n_fail++;
                $display("FAIL pack_word[%0d]: got %h want %h", i, got, e[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int ta, tn, dn;
        bit seen;
        wq_t e;
        logic [31:0] got;
        q.delete();
        start = 1; tick(); start = 0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            seen = triger;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL bp_triger: got no triger within 50 cycles want one");
        end
        // Stall ends on the 10th held cycle of a completed word: one drop exactly.
        tick(21);
        word_ready = 0;
        tick(12);
        word_ready = 1;
        wait_idle(0, ta, tn, dn);
        n_checks++;
        if (overflow !== 1'b1 || dn !== 1) begin
            n_fail++;
            $display("FAIL bp_overflow: got ov=%b pulses=%0d want 1 1", overflow, dn);
        end
        e = mk_exp(4, 15, 32'h4000_0000, 32'hC000_0000,
                   {2'b10, 1'b1, 13'b0, 16'(exp_cnt)});
        exp_cnt++;
        n_checks++;
        if (q.size() !== e.size()) begin
            n_fail++;
            $display("FAIL bp_len: got %0d words want %0d", q.size(), e.size());
        end
        for (int i = 0; i < e.size(); i++) begin
            got = (i < q.size()) ? q[i] : 'x;
            n_checks++;
            if (got !== e[i]) begin
                n_fail++;
                $display("FAIL bp_word[%0d]: got %h want %h", i, got, e[i]);
            end
        end
        q.delete();
        start = 1; tick(); start = 0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_clear: got ov=%b want 0", overflow);
        end
        wait_idle(0, ta, tn, dn);
        n_checks++;
        got = (q.size() > 0) ? q[q.size() - 1] : 'x;
        if (got !== {2'b10, 1'b0, 13'b0, 16'(exp_cnt)}) begin
            n_fail++;
            $display("FAIL bp_next_trailer: got %h want %h", got,
                     {2'b10, 1'b0, 13'b0, 16'(exp_cnt)});
        end
        exp_cnt++;
    endtask

    task automatic test_link_loss();
        int dn;
        bit seen;
        start = 1; tick(); start = 0;
        tick(7);
        n_checks++;
        if ({busy, swing_en} !== 2'b11) begin
            n_fail++;
            $display("FAIL ll_settle: got busy=%b swing=%b want 1 1", busy, swing_en);
        end
        link_up = 0; tick(); link_up = 1;
        n_checks++;
        if ({busy, swing_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL ll_settle_abort: got busy=%b swing=%b want 0 0", busy, swing_en);
        end
        start = 1; tick(); start = 0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            seen = triger;
        end
        tick(15);
        link_up = 0; tick(); link_up = 1;
        n_checks++;
        if ({seen, busy, swing_en} !== 3'b100) begin
            n_fail++;
            $display("FAIL ll_capture_abort: got trig=%b busy=%b swing=%b want 1 0 0",
                     seen, busy, swing_en);
        end
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (frame_done || busy) dn++;
        end
        n_checks++;
        if (dn !== 0 || frame_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL ll_no_done: got events=%0d cnt=%0d want 0 %0d", dn, frame_cnt, exp_cnt);
        end
        link_up = 0; start = 1;
        tick(3);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ll_start_ignored: got busy=%b want 0", busy);
        end
        start = 0; link_up = 1;
        tick();
    endtask

    task automatic test_reset_mid();
        int ta;
        start = 1; tick();
        ta = -1;
        for (int i = 1; i <= 50 && ta < 0; i++) begin
            tick();
            if (triger) ta = i;
        end
        n_checks++;
        if (ta !== 13) begin
            n_fail++;
            $display("FAIL start_busy: got triger at %0d want 13", ta);
        end
        tick(5);
        reset = 1;
        #1;
        n_checks++;
        if ({gth_data, word_valid, swing_en, triger, busy, frame_done, frame_cnt, overflow}
            !== {IDLE_W, 5'b0, 16'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: got data=%h v=%b sw=%b tr=%b bz=%b fd=%b cnt=%h ov=%b",
                     gth_data, word_valid, swing_en, triger, busy, frame_done, frame_cnt, overflow);
        end
        start = 0;
        tick();
        reset = 0;
        exp_cnt = 0;
        tick(2);
    endtask

    task automatic test_wrap();
        int ta, tn, dn;
        wq_t e;
        logic [31:0] got;
        force dut_min.frame_cnt = 16'hFFFE;
        #1;
        release dut_min.frame_cnt;
        for (int f = 0; f < 2; f++) begin
            q2.delete();
            start2 = 1; tick(); start2 = 0;
            wait_idle(1, ta, tn, dn);
            n_checks++;
            if (ta !== 3 || dn !== 1) begin
                n_fail++;
                $display("FAIL wrap_timing[%0d]: got trig_at=%0d done=%0d want 3 1", f, ta, dn);
            end
            e = mk_exp(1, 1, 32'hC000_0000, 32'hC000_0000,
                       (f == 0) ? 32'h8000_FFFE : 32'h8000_FFFF);
            n_checks++;
            if (q2.size() !== e.size()) begin
                n_fail++;
                $display("FAIL wrap_len[%0d]: got %0d words want %0d", f, q2.size(), e.size());
            end
            for (int i = 0; i < e.size(); i++) begin
                got = (i < q2.size()) ? q2[i] : 'x;
                n_checks++;
                if (got !== e[i]) begin
                    n_fail++;
                    $display("FAIL wrap_word[%0d][%0d]: got %h want %h", f, i, got, e[i]);
                end
            end
            n_checks++;
            if (frame_cnt2 !== ((f == 0) ? 16'hFFFF : 16'h0000)) begin
                n_fail++;
                $display("FAIL wrap_cnt[%0d]: got %h want %h", f, frame_cnt2,
                         (f == 0) ? 16'hFFFF : 16'h0000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_packing();
        test_backpressure();
        test_link_loss();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
